// File: rtl/vdp_affine_pkg.sv
// Shared types for the affine background layers: out-of-bounds modes, FSM states,
// the captured transform set and the accumulator width rule.
package vdp_affine_pkg;

    typedef enum logic [1:0] {
        OOB_TRANSPARENT = 2'd0,
        OOB_WRAP        = 2'd1,
        OOB_PLACEHOLDER = 2'd2,
        OOB_RESERVED    = 2'd3
    } oob_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2
    } state_e;

    typedef struct packed {
        logic signed [15:0] ptx, pty, tx, ty, a, b, c, d;
        oob_mode_e          oob;
        logic [7:0]         ph;
    } xform_t;

    // 16-bit integer part, FRAC_BITS fraction, two guard bits for the sums
    function automatic int acc_width(input int frac_bits);
        return 16 + frac_bits + 2;
    endfunction

endpackage

// File: rtl/vdp_affine_scanline_if.sv
// Even (map) / odd (char) VRAM read ports shared by the affine layers.
interface vdp_affine_scanline_if;
    logic [13:0] vram_even_address;
    logic [15:0] vram_even_data;
    logic [13:0] vram_odd_address;
    logic [15:0] vram_odd_data;

    modport master(output vram_even_address, vram_odd_address,
                   input  vram_even_data, vram_odd_data);
    modport slave (input  vram_even_address, vram_odd_address,
                   output vram_even_data, vram_odd_data);
endinterface

// File: rtl/delay_ff.sv
// Fixed-depth register delay line used for all VRAM-latency alignment.
module delay_ff #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];
endmodule

// File: rtl/vdp_affine_fetch.sv
// Two-stage map -> char fetch: map word on the even port, char pixel word on the
// odd port, byte selects carried alongside the VRAM latency; registered pixel out.
module vdp_affine_fetch #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue,
    input  logic [13:0] map_word,
    input  logic        map_sel,
    input  logic [2:0]  char_y,
    input  logic [2:0]  char_x,
    input  logic        blank,
    input  logic        use_ph,
    input  logic [7:0]  ph_char,
    vdp_affine_scanline_if.master vram,
    output logic [7:0]  pixel,
    output logic        valid
);
    logic [17:0] s1_q;
    logic [2:0]  s2_q;
    logic        s1_vld, s1_sel, s1_blank, s1_ph;
    logic [2:0]  s1_cy, s1_cx;
    logic [7:0]  s1_phc, map_byte, char_id;

    assign vram.vram_even_address = issue ? map_word : '0;

    delay_ff #(.WIDTH(18), .DEPTH(LAT)) u_map_dly (
        .clk(clk), .reset(reset),
        .d({issue, map_sel, char_y, char_x, blank, use_ph, ph_char}),
        .q(s1_q)
    );
    assign {s1_vld, s1_sel, s1_cy, s1_cx, s1_blank, s1_ph, s1_phc} = s1_q;

    // Out-of-bounds substitute char id replaces the map byte, not the char coordinates
    assign map_byte = s1_sel ? vram.vram_even_data[15:8] : vram.vram_even_data[7:0];
    assign char_id  = s1_ph ? s1_phc : map_byte;
    assign vram.vram_odd_address = s1_vld ? {1'b0, char_id, s1_cy, s1_cx[2:1]} : '0;

    delay_ff #(.WIDTH(3), .DEPTH(LAT)) u_chr_dly (
        .clk(clk), .reset(reset),
        .d({s1_vld, s1_blank, s1_cx[0]}),
        .q(s2_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel <= '0;
            valid <= 1'b0;
        end else begin
            valid <= s2_q[2];
            if (s2_q[2] && !s2_q[1])
                pixel <= s2_q[0] ? vram.vram_odd_data[15:8] : vram.vram_odd_data[7:0];
            else
                pixel <= '0;
        end
    end
endmodule

// File: rtl/vdp_affine_scanline.sv
// Affine background layer: per-line origin via multipliers, per-pixel accumulator step.
// Optional VDP_AFFINE_MOSAIC_EN adds mosaic_size (hold sampled coordinate N+1 pixels).
module vdp_affine_scanline
    import vdp_affine_pkg::*;
#(
    parameter int VRAM_READ_LATENCY = 3,
    parameter int FRAC_BITS         = 10,
    parameter int MAP_SIZE_LOG2     = 7,
    parameter int LINE_PIXELS       = 848
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               line_start,
    input  logic [8:0]         line_y,
    input  logic               params_write,
    input  logic signed [15:0] pretranslate_x,
    input  logic signed [15:0] pretranslate_y,
    input  logic signed [15:0] translate_x,
    input  logic signed [15:0] translate_y,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    input  logic signed [15:0] c,
    input  logic signed [15:0] d,
    input  logic [1:0]         oob_mode,
    input  logic [7:0]         placeholder_char,
`ifdef VDP_AFFINE_MOSAIC_EN
    input  logic [3:0]         mosaic_size,
`endif
    vdp_affine_scanline_if.master vram,
    output logic [7:0]         output_pixel,
    output logic               output_valid,
    output logic               busy
);
    localparam int W  = acc_width(FRAC_BITS);
    localparam int TW = W - FRAC_BITS;
    localparam int PB = MAP_SIZE_LOG2 + 3;
    localparam int CW = $clog2(LINE_PIXELS);
    localparam logic signed [W-1:0] HALF = {{(W-1){1'b0}}, 1'b1} <<< (FRAC_BITS - 1);

    function automatic logic signed [W-1:0] sx(input logic signed [15:0] v);
        return W'(v);
    endfunction

    state_e                state, state_n;
    xform_t                stg, act;
    logic [8:0]            ly;
    logic                  setup_ph, issue;
    logic signed [W-1:0]   p_xa, p_xb, p_yc, p_yd, xacc, yacc, ly_off;
    logic [CW-1:0]         pix_cnt;
    logic [TW-1:0]         xs, ys;
    logic                  oob, blank, use_ph;
    logic [MAP_SIZE_LOG2-1:0] map_x, map_y;

    assign issue  = (state == RUN) && !line_start;
    assign busy   = (state != IDLE);
    assign ly_off = $signed({{(W-9){1'b0}}, ly}) + sx(act.pty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (line_start) begin
            state_n = SETUP;
        end else begin
            case (state)
                SETUP:   if (setup_ph) state_n = RUN;
                RUN:     if (pix_cnt == CW'(LINE_PIXELS - 1)) state_n = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg <= '0;  act <= '0;  ly <= '0;  setup_ph <= 1'b0;
            p_xa <= '0; p_xb <= '0; p_yc <= '0; p_yd <= '0;
            xacc <= '0; yacc <= '0; pix_cnt <= '0;
        end else begin
            if (params_write)
                stg <= '{pretranslate_x, pretranslate_y, translate_x, translate_y,
                         a, b, c, d, oob_mode_e'(oob_mode), placeholder_char};
            if (line_start) begin
                act      <= stg;
                ly       <= line_y;
                setup_ph <= 1'b0;
            end else if (state == SETUP) begin
                setup_ph <= 1'b1;
                if (!setup_ph) begin
                    p_xa <= sx(act.ptx) * sx(act.a);
                    p_xb <= ly_off * sx(act.b);
                    p_yc <= sx(act.ptx) * sx(act.c);
                    p_yd <= ly_off * sx(act.d);
                end else begin
                    xacc    <= p_xa + p_xb + (sx(act.tx) <<< FRAC_BITS) + HALF;
                    yacc    <= p_yc + p_yd + (sx(act.ty) <<< FRAC_BITS) + HALF;
                    pix_cnt <= '0;
                end
            end else if (state == RUN) begin
                xacc    <= xacc + sx(act.a);
                yacc    <= yacc + sx(act.c);
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

`ifdef VDP_AFFINE_MOSAIC_EN
    logic [3:0]    mos_stg, mos_act, hold_cnt;
    logic [TW-1:0] hold_x, hold_y;

    assign xs = (hold_cnt == 4'd0) ? xacc[W-1:FRAC_BITS] : hold_x;
    assign ys = (hold_cnt == 4'd0) ? yacc[W-1:FRAC_BITS] : hold_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mos_stg <= '0; mos_act <= '0; hold_cnt <= '0; hold_x <= '0; hold_y <= '0;
        end else begin
            if (params_write) mos_stg <= mosaic_size;
            if (line_start) mos_act <= mos_stg;
            if (state == SETUP) begin
                hold_cnt <= '0;
            end else if (issue) begin
                if (hold_cnt == 4'd0) begin
                    hold_x <= xacc[W-1:FRAC_BITS];
                    hold_y <= yacc[W-1:FRAC_BITS];
                end
                hold_cnt <= (hold_cnt == mos_act) ? 4'd0 : hold_cnt + 4'd1;
            end
        end
    end
`else
    assign xs = xacc[W-1:FRAC_BITS];
    assign ys = yacc[W-1:FRAC_BITS];
`endif

    // Negative coordinates have the top bit set, so one OR-reduce covers both cases
    assign oob    = (|xs[TW-1:PB]) || (|ys[TW-1:PB]);
    assign blank  = oob && !(act.oob == OOB_WRAP || act.oob == OOB_PLACEHOLDER);
    assign use_ph = oob && (act.oob == OOB_PLACEHOLDER);
    assign map_x  = xs[PB-1:3];
    assign map_y  = ys[PB-1:3];

    vdp_affine_fetch #(.LAT(VRAM_READ_LATENCY)) u_fetch (
        .clk      (clk),
        .reset    (reset),
        .issue    (issue),
        .map_word (14'({map_y, map_x[MAP_SIZE_LOG2-1:1]})),
        .map_sel  (map_x[0]),
        .char_y   (ys[2:0]),
        .char_x   (xs[2:0]),
        .blank    (blank),
        .use_ph   (use_ph),
        .ph_char  (act.ph),
        .vram     (vram),
        .pixel    (output_pixel),
        .valid    (output_valid)
    );
endmodule
